// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core: stage-register stall/flush
// control, E-stage forwarding selects, data-memory wait states and mult/div busy tracking.
module hazard_ctrl #(
  parameter int unsigned DM_LAT = 2,
  parameter int unsigned MD_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [4:0] rs_E,
  input  logic [4:0] rt_E,
  input  logic [4:0] rf_wa_E,
  input  logic [4:0] rf_wa_M,
  input  logic [4:0] rf_wa_W,
  input  logic       we_reg_E,
  input  logic       we_reg_M,
  input  logic       we_reg_W,
  input  logic       dm2reg_E,
  input  logic       dm2reg_M,
  input  logic       we_dm_M,
  input  logic       redirect_M,
  input  logic       md_start_E,
  input  logic       md_op_D,
  input  logic       hilo_rd_D,
  output logic       stall_pc,
  output logic       stall_f2d,
  output logic       stall_d2e,
  output logic       stall_e2m,
  output logic       flush_f2d,
  output logic       flush_d2e,
  output logic       flush_e2m,
  output logic       flush_m2w,
  output logic [1:0] fwd_a_E,
  output logic [1:0] fwd_b_E
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [3:0] MEM_LOAD = (DM_LAT > 1) ? 4'(DM_LAT - 2) : 4'd0;
  localparam logic [4:0] MD_LOAD  = 5'(MD_LAT - 1);

  logic [0:0] state_q, state_d;
  logic [3:0] mem_cnt_q, mem_cnt_d;
  logic [4:0] md_cnt_q, md_cnt_d;

  logic mem_req, mem_stall, md_busy, md_hz, lu_hz;

  assign mem_req = dm2reg_M | we_dm_M;

  always_comb begin
    state_d   = state_q;
    mem_cnt_d = mem_cnt_q;
    mem_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_req && (DM_LAT > 1)) begin
          mem_stall = 1'b1;
          mem_cnt_d = MEM_LOAD;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        // Count 0 releases the stall so the held access completes on this edge.
        if (mem_cnt_q != '0) begin
          mem_stall = 1'b1;
          mem_cnt_d = mem_cnt_q - 4'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start_E && !stall_d2e) begin
      md_cnt_d = MD_LOAD;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mem_cnt_q <= '0;
      md_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      mem_cnt_q <= mem_cnt_d;
      md_cnt_q  <= md_cnt_d;
    end
  end

  assign md_busy = (md_cnt_q != '0);
  assign md_hz   = md_busy & (hilo_rd_D | md_op_D);
  assign lu_hz   = dm2reg_E & we_reg_E & (rf_wa_E != '0) &
                   ((rf_wa_E == rs_D) | (rf_wa_E == rt_D));

  // rst gates the outputs directly so a held mem_req in IDLE cannot stall during reset.
  always_comb begin
    stall_pc  = 1'b0;
    stall_f2d = 1'b0;
    stall_d2e = 1'b0;
    stall_e2m = 1'b0;
    flush_f2d = 1'b0;
    flush_d2e = 1'b0;
    flush_e2m = 1'b0;
    flush_m2w = 1'b0;
    if (rst) begin
      stall_pc = 1'b0;
    end else if (mem_stall) begin
      stall_pc  = 1'b1;
      stall_f2d = 1'b1;
      stall_d2e = 1'b1;
      stall_e2m = 1'b1;
      flush_m2w = 1'b1;
    end else if (redirect_M) begin
      flush_f2d = 1'b1;
      flush_d2e = 1'b1;
      flush_e2m = 1'b1;
    end else if (lu_hz || md_hz) begin
      stall_pc  = 1'b1;
      stall_f2d = 1'b1;
      flush_d2e = 1'b1;
    end
  end

  always_comb begin
    fwd_a_E = 2'b00;
    fwd_b_E = 2'b00;
    if (!rst) begin
      if (we_reg_M && (rf_wa_M != '0) && (rf_wa_M == rs_E))      fwd_a_E = 2'b10;
      else if (we_reg_W && (rf_wa_W != '0) && (rf_wa_W == rs_E)) fwd_a_E = 2'b01;
      if (we_reg_M && (rf_wa_M != '0) && (rf_wa_M == rt_E))      fwd_b_E = 2'b10;
      else if (we_reg_W && (rf_wa_W != '0) && (rf_wa_W == rt_E)) fwd_b_E = 2'b01;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage MIPS core. It drives the stall and flush inputs of all stage registers, including stall_e2m, which freezes the execute-to-memory register. It also generates the E-stage forwarding selects. Two sequential trackers handle timing: a data-memory wait-state counter and a multi-cycle multiply/divide busy counter. Together with the stage registers, these decide what every pipeline register does on each clock.

Parameters:
DM_LAT, 2, data-memory access latency in cycles, range 1..15; an instruction with a memory access occupies M for DM_LAT cycles.
MD_LAT, 4, mult/div latency in cycles from md_start_E until HI/LO is valid, range 1..31.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
rs_D, rt_D  in  5  source registers of the instruction in D
rs_E, rt_E  in  5  source registers of the instruction in E
rf_wa_E, rf_wa_M, rf_wa_W  in  5  destination register per stage
we_reg_E, we_reg_M, we_reg_W  in  1  register-file write enable per stage
dm2reg_E  in  1  instruction in E is a load
dm2reg_M, we_dm_M  in  1  instruction in M reads / writes data memory
redirect_M  in  1  taken branch, jump or register jump resolved in M
md_start_E  in  1  mult/div instruction in E
md_op_D, hilo_rd_D  in  1  instruction in D is mult/div / reads HI or LO
stall_pc, stall_f2d, stall_d2e, stall_e2m  out  1  hold PC / the corresponding stage register
flush_f2d, flush_d2e, flush_e2m, flush_m2w  out  1  clear the corresponding stage register to a bubble
fwd_a_E, fwd_b_E  out  2  E-operand select: 00 = register file, 01 = W result, 10 = M alu_out

Behaviour:
- Reset: mem FSM = IDLE, mem_cnt = 0, md_cnt = 0. All outputs are combinational from state and inputs; with all inputs 0, every output is 0.
- mem_req = dm2reg_M | we_dm_M.
- Mem FSM, state IDLE:
  - If mem_req and DM_LAT > 1: assert mem_stall, load mem_cnt = DM_LAT-2, go to WAIT.
  - If DM_LAT = 1: never stall.
- Mem FSM, state WAIT:
  - mem_stall = (mem_cnt != 0).
  - mem_cnt != 0: decrement.
  - mem_cnt == 0: release the stall this cycle and return to IDLE. The held instruction advances on this edge, so the next mem_req seen in IDLE belongs to a new instruction.
  - Back-to-back memory instructions each incur DM_LAT-1 stall cycles.
- mem_stall effect: stall_pc = stall_f2d = stall_d2e = stall_e2m = 1 and flush_m2w = 1 (bubble into W). Forwarding is unaffected.
- MD tracker:
  - On md_start_E & ~stall_d2e: md_cnt <= MD_LAT-1. Otherwise, if md_cnt != 0, decrement.
  - md_busy = (md_cnt != 0).
  - md_hz = md_busy & (hilo_rd_D | md_op_D): assert stall_pc, stall_f2d, flush_d2e.
- Load-use hazard: lu_hz = dm2reg_E & we_reg_E & (rf_wa_E != 0) & (rf_wa_E == rs_D | rf_wa_E == rt_D). Effect: stall_pc, stall_f2d, flush_d2e.
- Redirect: redirect_M -> flush_f2d, flush_d2e, flush_e2m. It overrides lu_hz and md_hz: their stalls drop and the flush wins.
- Priority, highest first: mem_stall > redirect_M > (lu_hz | md_hz).
  - While mem_stall is asserted, every flush except flush_m2w is 0.
  - The md_cnt decrement continues during stalls.
- Forwarding, fwd_a_E (same rule for fwd_b_E with rt_E):
  - 10 if we_reg_M & rf_wa_M != 0 & rf_wa_M == rs_E.
  - Else 01 if we_reg_W & rf_wa_W != 0 & rf_wa_W == rs_E.
  - Else 00.
  - M takes priority over W. Register 0 never forwards.
- Reset mid-operation: an asserted rst returns both trackers to idle immediately and drops all stalls in the same cycle.

Test Plan:
1. DM_LAT=3; lw in M (dm2reg_M=1) for 3 cycles -> stall_e2m/stall_d2e/stall_f2d/stall_pc/flush_m2w = 1 for exactly 2 cycles, 0 on the 3rd; two consecutive loads -> two separate 2-cycle stall windows.
2. Load-use: dm2reg_E=1, we_reg_E=1, rf_wa_E=8, rs_D=8 -> stall_pc=stall_f2d=flush_d2e=1, stall_e2m=0; same with rf_wa_E=0 -> no stall.
3. Forwarding: rf_wa_M=5 and rf_wa_W=5, both we_reg=1, rs_E=5 -> fwd_a_E=10; clear we_reg_M -> fwd_a_E=01; rt_E=0 with rf_wa_M=0 -> fwd_b_E=00.
4. MD_LAT=4; pulse md_start_E, then hilo_rd_D=1 held -> stall_f2d/flush_d2e asserted 3 cycles, released on the 4th.
5. redirect_M=1 together with lu_hz -> flush_f2d/d2e/e2m=1, stall_f2d=0; redirect_M=1 during mem_stall -> only stalls plus flush_m2w.
6. Assert rst mid-WAIT (DM_LAT=8) -> all outputs 0 immediately; after release, the first mem_req restarts a full 7-cycle stall.
